// File: rtl/m_bart_uart_tx_if.sv
// rtl/m_bart_uart_tx_if.sv - host-side register/serial bundle for the BART transmitter
interface m_bart_uart_tx_if #(
  parameter int DIV_WIDTH = 12
);
  logic [DIV_WIDTH-1:0] DIVISOR;
  logic                 PAREN;
  logic                 PARODD;
  logic                 WR;
  logic [7:0]           DIN;
  logic                 CLROVR;
  logic                 TXD;
  logic                 THRE;
  logic                 TXBUSY;
  logic                 OVR;

  // Host register logic drives configuration and writes, observes status
  modport master (
    output DIVISOR, PAREN, PARODD, WR, DIN, CLROVR,
    input  TXD, THRE, TXBUSY, OVR
  );

  // Transmitter consumes configuration and writes, drives line and status
  modport slave (
    input  DIVISOR, PAREN, PARODD, WR, DIN, CLROVR,
    output TXD, THRE, TXBUSY, OVR
  );
endinterface

// File: rtl/m_bart_uart_tx.sv
// rtl/m_bart_uart_tx.sv - BART serial transmitter with holding register and optional parity
module m_bart_uart_tx #(
  parameter int DIV_WIDTH = 12
) (
  input  logic             MasterClock,
  input  logic             RESETL,
  m_bart_uart_tx_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic [2:0]           bit_q, bit_d;
  logic [7:0]           shift_q, shift_d;
  logic [7:0]           hold_q, hold_d;
  logic                 thre_q, thre_d;
  logic                 ovr_q, ovr_d;
  logic                 txd_q, txd_d;
  logic                 busy_q, busy_d;
  logic                 paren_q, paren_d;
  logic                 par_q, par_d;
  logic                 load;
  logic                 bit_end;

  // A bit period ends on the edge where the counter reaches the divisor latched for this frame
  assign bit_end = (cnt_q == div_q);

  // State and datapath registers; reset forces the line idle and discards everything
  always_ff @(posedge MasterClock or negedge RESETL) begin
    if (!RESETL) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      div_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      hold_q  <= '0;
      thre_q  <= 1'b1;
      ovr_q   <= 1'b0;
      txd_q   <= 1'b1;
      busy_q  <= 1'b0;
      paren_q <= 1'b0;
      par_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      hold_q  <= hold_d;
      thre_q  <= thre_d;
      ovr_q   <= ovr_d;
      txd_q   <= txd_d;
      busy_q  <= busy_d;
      paren_q <= paren_d;
      par_q   <= par_d;
    end
  end

  // Next-state: host writes, frame sequencing, and holding-to-shifter transfer
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    hold_d  = hold_q;
    thre_d  = thre_q;
    ovr_d   = ovr_q;
    txd_d   = txd_q;
    paren_d = paren_q;
    par_d   = par_q;
    load    = 1'b0;

    // Clear first so a rejected write in the same cycle leaves OVR set
    if (bus.CLROVR) begin
      ovr_d = 1'b0;
    end
    // THRE is still 0 on a transfer edge, so a colliding write is rejected
    if (bus.WR) begin
      if (thre_q) begin
        hold_d = bus.DIN;
        thre_d = 1'b0;
      end else begin
        ovr_d = 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        txd_d = 1'b1;
        cnt_d = '0;
        if (!thre_q) begin
          load = 1'b1;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          cnt_d   = '0;
          bit_d   = 3'd0;
          txd_d   = shift_q[0];
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_d = '0;
          if (bit_q == 3'd7) begin
            if (paren_q) begin
              state_d = PARITY;
              txd_d   = par_q;
            end else begin
              state_d = STOP;
              txd_d   = 1'b1;
            end
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
            txd_d   = shift_q[1];
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
          cnt_d   = '0;
          txd_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          cnt_d = '0;
          if (!thre_q) begin
            load = 1'b1;
          end else begin
            state_d = IDLE;
            txd_d   = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        txd_d   = 1'b1;
        cnt_d   = '0;
      end
    endcase

    // Frame start: move the byte out of holding and freeze the line configuration
    if (load) begin
      state_d = START;
      cnt_d   = '0;
      shift_d = hold_q;
      thre_d  = 1'b1;
      div_d   = bus.DIVISOR;
      paren_d = bus.PAREN;
      par_d   = (^hold_q) ^ bus.PARODD;
      txd_d   = 1'b0;
    end

    busy_d = (state_d != IDLE);
  end

  assign bus.TXD    = txd_q;
  assign bus.THRE   = thre_q;
  assign bus.TXBUSY = busy_q;
  assign bus.OVR    = ovr_q;

endmodule
